weight_load_sequencer: RTL and testbench

Reads one kernel's worth of weight words from the weight BRAM and streams them into the per-MAC weight preload shift registers in `MAC_array_control`. After the last word, it issues the single-cycle commit that transfers the preloaded weights into the MAC array. It is the producer end of the `weight_from_bram` / `load_weight_preload` / `load_MAC_weight` interface, and sits between the weight BRAM port and `MAC_array_control`.

---
 rtl/weight_load_sequencer_pkg.sv | 23 ++
 rtl/weight_load_sequencer.sv | 104 ++++++++++
 tb/tb_weight_load_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_load_sequencer_pkg.sv
// Shared constants and state encoding for the weight preload sequencer.
package weight_load_sequencer_pkg;

  localparam int KERNEL_SIZE_MAX = 5;
  localparam int WEIGHT_BITS     = 5;
  localparam int TAP_MAX         = 25;
  localparam int CNT_W           = $clog2(TAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Number of taps in a K x K kernel; K is pre-qualified to 1..KERNEL_SIZE_MAX.
  function automatic logic [CNT_W-1:0] tap_count(input logic [4:0] k);
    logic [9:0] prod;
    prod = {5'd0, k} * {5'd0, k};
    return prod[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/weight_load_sequencer.sv
// Streams one kernel of weight words from BRAM into the MAC preload shift
// registers, then issues the single-cycle commit into the MAC array.
module weight_load_sequencer
  import weight_load_sequencer_pkg::*;
#(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [4:0]                         kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0]      base_addr,
  output logic                               bram_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0]      bram_addr,
  input  logic [WEIGHT_BITS*MAC_NUM-1:0]     bram_rdata,
  output logic [WEIGHT_BITS*MAC_NUM-1:0]     weight_from_bram,
  output logic                               load_weight_preload,
  output logic                               load_MAC_weight,
  output logic                               busy,
  output logic                               done,
  output logic                               error
);

  state_t           state;
  logic [CNT_W-1:0] n_taps;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] push_cnt;
  logic             rd_vld_p0;
  logic             k_legal;

  assign k_legal = (kernel_size != 5'd0) && (kernel_size <= 5'(KERNEL_SIZE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      n_taps              <= '0;
      issue_cnt           <= '0;
      push_cnt            <= '0;
      rd_vld_p0           <= 1'b0;
      bram_en             <= 1'b0;
      bram_addr           <= '0;
      weight_from_bram    <= '0;
      load_weight_preload <= 1'b0;
      load_MAC_weight     <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      error <= 1'b0;

      // p0: read data returns one cycle after bram_en; register it and strobe.
      rd_vld_p0           <= bram_en;
      load_weight_preload <= rd_vld_p0;
      if (rd_vld_p0) begin
        weight_from_bram <= bram_rdata;
        push_cnt         <= push_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (k_legal) begin
              state     <= READ;
              bram_en   <= 1'b1;
              bram_addr <= base_addr;
              n_taps    <= tap_count(kernel_size);
              issue_cnt <= '0;
              push_cnt  <= '0;
              busy      <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue_cnt == n_taps - CNT_W'(1)) begin
            bram_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            // Address wraps modulo 2^BRAM_ADDRESS_WIDTH by construction.
            bram_addr <= bram_addr + BRAM_ADDRESS_WIDTH'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (push_cnt == n_taps) begin
            state           <= COMMIT;
            load_MAC_weight <= 1'b1;
            done            <= 1'b1;
          end
        end
        COMMIT: begin
          state           <= IDLE;
          load_MAC_weight <= 1'b0;
          done            <= 1'b0;
          busy            <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Bench for weight_load_sequencer: vector table plus scoreboard of expected
// reads, strobes, commits and errors, keyed by cycle number.
module tb_weight_load_sequencer;

  localparam int MACS = 4;
  localparam int AW   = 12;
  localparam int DW   = 5 * MACS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4:0]    kernel_size;
  logic [AW-1:0] base_addr;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] weight_from_bram;
  logic          load_weight_preload;
  logic          load_MAC_weight;
  logic          busy;
  logic          done;
  logic          error;

  weight_load_sequencer #(.MAC_NUM(MACS), .BRAM_ADDRESS_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .kernel_size         (kernel_size),
    .base_addr           (base_addr),
    .bram_en             (bram_en),
    .bram_addr           (bram_addr),
    .bram_rdata          (bram_rdata),
    .weight_from_bram    (weight_from_bram),
    .load_weight_preload (load_weight_preload),
    .load_MAC_weight     (load_MAC_weight),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, ~a};
  endfunction

  // BRAM model with fixed one-cycle read latency.
  always @(posedge clk) begin
    if (bram_en) bram_rdata <= word_of(bram_addr);
  end
  initial bram_rdata = '0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] val;
  } ev_t;

  ev_t addr_q[$];
  ev_t data_q[$];
  int  commit_q[$];
  int  err_q[$];
  int  b_from = 1;
  int  b_to   = 0;
  int  t0;
  int  strobe_cnt, commit_cnt, err_cnt, done_cyc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bram_en"}, 32'(bram_en), 0);
    chk({tag, "_bram_addr"}, 32'(bram_addr), 0);
    chk({tag, "_weight"}, 32'(weight_from_bram), 0);
    chk({tag, "_strobe"}, 32'(load_weight_preload), 0);
    chk({tag, "_commit"}, 32'(load_MAC_weight), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // Scoreboard monitor, sampling at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      int  c;
      chk("busy", 32'(busy), 32'((cyc >= b_from) && (cyc <= b_to)));
      if (bram_en) begin
        if (addr_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = addr_q.pop_front();
          chk("read_cycle", 32'(cyc), 32'(e.cyc));
          chk("read_addr", 32'(bram_addr), 32'(e.val));
        end
      end
      if (load_weight_preload) begin
        strobe_cnt++;
        if (data_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = data_q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("strobe_data", 32'(weight_from_bram), 32'(e.val));
        end
      end
      if (load_MAC_weight || done) begin
        commit_cnt++;
        done_cyc = cyc;
        chk("commit_done_pair", {31'd0, load_MAC_weight}, {31'd0, done});
        if (commit_q.size() == 0) chk("unexpected_commit", 1, 0);
        else begin
          c = commit_q.pop_front();
          chk("commit_cycle", 32'(cyc), 32'(c));
        end
      end
      if (error) begin
        err_cnt++;
        if (err_q.size() == 0) chk("unexpected_error", 1, 0);
        else begin
          c = err_q.pop_front();
          chk("error_cycle", 32'(cyc), 32'(c));
        end
      end
    end
  end

  // Drive start for one sampling edge and register the expected behaviour.
  task automatic launch(input logic [4:0] k, input logic [AW-1:0] base);
    int n;
    strobe_cnt = 0;
    commit_cnt = 0;
    err_cnt    = 0;
    done_cyc   = -1;
    start       = 1'b1;
    kernel_size = k;
    base_addr   = base;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    kernel_size = 5'($urandom_range(0, 31));
    base_addr   = AW'($urandom);
    if (k >= 1 && k <= 5) begin
      n = int'(k) * int'(k);
      for (int i = 0; i < n; i++) begin
        addr_q.push_back('{t0 + i, DW'(AW'(base + AW'(i))) });
        data_q.push_back('{t0 + 2 + i, word_of(AW'(base + AW'(i)))});
      end
      commit_q.push_back(t0 + 2 + n);
      b_from = t0;
      b_to   = t0 + 2 + n;
    end else begin
      err_q.push_back(t0);
    end
  endtask

  task automatic wait_idle(input int maxc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (addr_q.size() == 0 && data_q.size() == 0 && commit_q.size() == 0 &&
          err_q.size() == 0 && cyc > b_to + 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle_timeout", {31'd0, ok}, 1);
  endtask

  typedef struct {
    logic [4:0]    k;
    logic [AW-1:0] base;
    int            exp_err;
    int            exp_n;
    int            exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, c1;
    logic hit;

    vecs[0] = '{5'd3, 12'h010, 0, 9, 12};
    vecs[1] = '{5'd1, 12'h100, 0, 1, 4};
    vecs[2] = '{5'd5, 12'hFF0, 0, 25, 28};
    vecs[3] = '{5'd0, 12'h020, 1, 0, 0};
    vecs[4] = '{5'd6, 12'h030, 1, 0, 0};
    vecs[5] = '{5'd2, 12'hFFF, 0, 4, 7};

    rst_n = 1'b0;
    start = 1'b0;
    kernel_size = '0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].k, vecs[i].base);
      wait_idle(100);
      chk($sformatf("vec%0d_strobes", i), 32'(strobe_cnt), 32'(vecs[i].exp_n));
      chk($sformatf("vec%0d_errors", i), 32'(err_cnt), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_commits", i), 32'(commit_cnt), 32'(1 - vecs[i].exp_err));
      if (vecs[i].exp_err == 0)
        chk($sformatf("vec%0d_latency", i), 32'(done_cyc - t0 + 1), 32'(vecs[i].exp_lat));
      @(posedge clk);
      #1;
    end

    // start re-asserted while busy is ignored; back-to-back start after done.
    launch(5'd4, 12'h500);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    kernel_size = 5'd2;
    base_addr = 12'h007;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (load_MAC_weight) begin
        hit = 1'b1;
        break;
      end
    end
    chk("k4_done_seen", {31'd0, hit}, 1);
    s1 = strobe_cnt;
    c1 = commit_cnt;
    start = 1'b1;
    kernel_size = 5'd3;
    base_addr = 12'h600;
    @(posedge clk);
    #1;
    chk("b2b_busy_after_done", 32'(busy), 0);
    launch(5'd3, 12'h600);
    wait_idle(100);
    chk("k4_strobes", 32'(s1), 16);
    chk("k4_commits", 32'(c1), 1);
    chk("b2b_strobes", 32'(strobe_cnt), 9);
    chk("b2b_commits", 32'(commit_cnt), 1);

    // Asynchronous reset at the 10th strobe of a K=5 load.
    @(posedge clk);
    #1;
    launch(5'd5, 12'h300);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt == 10) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_10th_strobe_seen", {31'd0, hit}, 1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    addr_q.delete();
    data_q.delete();
    commit_q.delete();
    err_q.delete();
    b_from = 1;
    b_to   = 0;
    commit_cnt = 0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("abort_no_commit", 32'(commit_cnt), 0);
    @(posedge clk);
    #1;
    launch(5'd2, 12'h400);
    wait_idle(100);
    chk("post_abort_strobes", 32'(strobe_cnt), 4);
    chk("post_abort_latency", 32'(done_cyc - t0 + 1), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
